// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: funct3 decode, FSM states, sign helpers.
package muldiv_unit_pkg;

    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011,
        div    = 3'b100,
        divu   = 3'b101,
        rem    = 3'b110,
        remu   = 3'b111
    } muldiv_funct3_t;

    localparam logic [6:0] funct7_muldiv = 7'b0000001;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } muldiv_state_t;

    function automatic logic op_signed_a(muldiv_funct3_t op);
        return op inside {mulh, mulhsu, div, rem};
    endfunction

    function automatic logic op_signed_b(muldiv_funct3_t op);
        return op inside {mulh, div, rem};
    endfunction

endpackage

// File: rtl/muldiv_unit_negate.sv
// Conditional two's-complement negation of an N-bit value.
module muldiv_negate #(
    parameter int unsigned N = 32
) (
    input  logic         en,
    input  logic [N-1:0] in_val,
    output logic [N-1:0] out_val
);

    always_comb begin
        out_val = in_val;
        if (en) begin
            out_val = ~in_val + {{(N-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, returning a tagged result over valid/ready.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned TAGW = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  muldiv_funct3_t  funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [TAGW-1:0] tag_in,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic [TAGW-1:0] tag_out,
    input  logic            flush
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0] LastCnt = CW'(XLEN - 1);

    muldiv_state_t   state_q, state_d;
    muldiv_funct3_t  op_q, op_d;
    logic [TAGW-1:0] tag_q, tag_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] shf_q, shf_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            a_neg_q, a_neg_d;
    logic            b_neg_q, b_neg_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] result_q, result_d;

    // Operand decode at acceptance
    logic            a_neg_in, b_neg_in;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_res;

    assign a_neg_in = op_signed_a(funct3) & rs1_data[XLEN-1];
    assign b_neg_in = op_signed_b(funct3) & rs2_data[XLEN-1];

    muldiv_negate #(.N(XLEN)) u_neg_a (
        .en      (a_neg_in),
        .in_val  (rs1_data),
        .out_val (a_mag)
    );

    muldiv_negate #(.N(XLEN)) u_neg_b (
        .en      (b_neg_in),
        .in_val  (rs2_data),
        .out_val (b_mag)
    );

    assign div_zero = funct3[2] && (rs2_data == '0);
    assign div_ovf  = ((funct3 == div) || (funct3 == rem)) && (rs1_data == MinNeg)
                      && (rs2_data == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? rs1_data : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : rs1_data;
        end
    end

    // Multiply step: acc holds the running high half, shf the multiplier shifting out.
    logic [XLEN:0]   add_sum;
    logic [XLEN-1:0] mul_acc, mul_shf;

    assign add_sum = {1'b0, acc_q} + (shf_q[0] ? {1'b0, opb_q} : '0);
    assign mul_acc = add_sum[XLEN:1];
    assign mul_shf = {add_sum[0], shf_q[XLEN-1:1]};

    // Restoring divide step: acc is the partial remainder, shf the dividend/quotient.
    logic [XLEN:0]   div_shifted, div_diff;
    logic            div_ge;
    logic [XLEN-1:0] div_acc, div_shf;

    assign div_shifted = {acc_q, shf_q[XLEN-1]};
    assign div_diff    = div_shifted - {1'b0, opb_q};
    assign div_ge      = ~div_diff[XLEN];
    assign div_acc     = div_ge ? div_diff[XLEN-1:0] : div_shifted[XLEN-1:0];
    assign div_shf     = {shf_q[XLEN-2:0], div_ge};

    logic            is_div_q;
    logic [XLEN-1:0] step_acc, step_shf;

    assign is_div_q = op_q[2];
    assign step_acc = is_div_q ? div_acc : mul_acc;
    assign step_shf = is_div_q ? div_shf : mul_shf;

    // Sign correction of the finished magnitude, applied on the last CALC cycle
    logic [2*XLEN-1:0] prod_signed;
    logic [XLEN-1:0]   div_mag, div_signed, mul_res, final_res;
    logic              div_neg;

    muldiv_negate #(.N(2 * XLEN)) u_neg_prod (
        .en      (a_neg_q ^ b_neg_q),
        .in_val  ({step_acc, step_shf}),
        .out_val (prod_signed)
    );

    assign div_mag = op_q[1] ? step_acc : step_shf;
    assign div_neg = op_q[1] ? a_neg_q : (a_neg_q ^ b_neg_q);

    muldiv_negate #(.N(XLEN)) u_neg_div (
        .en      (div_neg),
        .in_val  (div_mag),
        .out_val (div_signed)
    );

    assign mul_res   = (op_q == mul) ? prod_signed[XLEN-1:0] : prod_signed[2*XLEN-1:XLEN];
    assign final_res = is_div_q ? div_signed : mul_res;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        tag_d       = tag_q;
        acc_d       = acc_q;
        shf_d       = shf_q;
        opb_d       = opb_q;
        cnt_d       = cnt_q;
        a_neg_d     = a_neg_q;
        b_neg_d     = b_neg_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid && !flush) begin
                    op_d    = funct3;
                    tag_d   = tag_in;
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    acc_d   = '0;
                    shf_d   = a_mag;
                    opb_d   = b_mag;
                    cnt_d   = '0;
                    if (special) begin
                        state_d     = StDone;
                        result_d    = special_res;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                acc_d = step_acc;
                shf_d = step_shf;
                if (cnt_q == LastCnt) begin
                    cnt_d       = '0;
                    state_d     = StDone;
                    result_d    = final_res;
                    out_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = StIdle;
                out_valid_d = 1'b0;
            end
        endcase

        if (flush) begin
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= mul;
            tag_q       <= '0;
            acc_q       <= '0;
            shf_q       <= '0;
            opb_q       <= '0;
            cnt_q       <= '0;
            a_neg_q     <= 1'b0;
            b_neg_q     <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tag_q       <= tag_d;
            acc_q       <= acc_d;
            shf_q       <= shf_d;
            opb_q       <= opb_d;
            cnt_q       <= cnt_d;
            a_neg_q     <= a_neg_d;
            b_neg_q     <= b_neg_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign tag_out   = tag_q;

endmodule
